// File: rtl/dst40_pkg.sv
// rtl/dst40_pkg.sv - DST40 constants, FSM states and key/challenge step helpers
package dst40_pkg;

    localparam int DST40_W = 40;

    // Forward key feedback taps and forward challenge feedback taps.
    localparam int KEY_TAPS [4] = '{0, 2, 19, 21};
    localparam int CHAL_TAPS [2] = '{0, 2};

    // Round-function truth tables: five 4-input first-level cells, one 5-input combiner.
    localparam logic [15:0] F1_TAB [5] = '{16'h3A35, 16'hAC35, 16'hB874, 16'h1D17, 16'h4E72};
    localparam logic [31:0] FG_TAB = 32'h1F36_C59A;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FFWD,
        S_ROUND,
        S_DONE
    } state_t;

    // One forward key-schedule step: shift right, feedback enters at the top.
    function automatic logic [DST40_W-1:0] key_fwd(input logic [DST40_W-1:0] k);
        return {k[KEY_TAPS[0]] ^ k[KEY_TAPS[1]] ^ k[KEY_TAPS[2]] ^ k[KEY_TAPS[3]],
                k[DST40_W-1:1]};
    endfunction

    // Undo one key step: taps sit one position lower after the forward shift.
    function automatic logic [DST40_W-1:0] key_bwd(input logic [DST40_W-1:0] k);
        return {k[DST40_W-2:0],
                k[DST40_W-1] ^ k[KEY_TAPS[1]-1] ^ k[KEY_TAPS[2]-1] ^ k[KEY_TAPS[3]-1]};
    endfunction

    // Undo one Feistel round given f evaluated on the shifted-down state.
    function automatic logic [DST40_W-1:0] chal_bwd(input logic [DST40_W-1:0] c, input logic f);
        return {c[DST40_W-2:0], c[DST40_W-1] ^ c[CHAL_TAPS[1]-1] ^ f};
    endfunction

endpackage

// File: rtl/dst40_f.sv
// rtl/dst40_f.sv - combinational DST40 round function (Fa..Fe cells into Fg)
module dst40_f
    import dst40_pkg::*;
(
    input  logic [DST40_W-2:0] c,
    input  logic [DST40_W-1:0] k,
    output logic               f
);

    logic [DST40_W-1:0] mix;
    logic [9:0]         lvl1;

    // Mix state with key, feed ten nibbles through the first-level cells, combine in two Fg cells.
    always_comb begin
        mix = {k[DST40_W-1], c ^ k[DST40_W-2:0]};
        for (int i = 0; i < 10; i++) begin
            lvl1[i] = F1_TAB[i % 5][mix[4*i +: 4]];
        end
        f = FG_TAB[lvl1[4:0]] ^ FG_TAB[lvl1[9:5]];
    end

endmodule

// File: rtl/dst40_decrypt.sv
// rtl/dst40_decrypt.sv - iterative inverse DST40, one inverse round per clock
module dst40_decrypt
    import dst40_pkg::*;
#(
    parameter int ROUNDS     = 200,
    parameter int KEY_PERIOD = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DST40_W-1:0] in_state,
    input  logic [DST40_W-1:0] in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DST40_W-1:0] out_chal,
    output logic               busy
);

    localparam int NSTEP    = (ROUNDS - 1) / KEY_PERIOD;
    localparam int NSTEP_M1 = (NSTEP > 0) ? NSTEP - 1 : 0;
    localparam int RW       = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int CW       = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int PW       = (KEY_PERIOD > 1) ? $clog2(KEY_PERIOD) : 1;

    localparam logic [RW-1:0] R_LAST    = RW'(ROUNDS - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(NSTEP_M1);
    localparam logic [PW-1:0] PH_RELOAD = PW'(KEY_PERIOD - 1);
    localparam logic [PW-1:0] PH_START  = PW'((ROUNDS - 1) % KEY_PERIOD);

    state_t             state, state_n;
    logic [DST40_W-1:0] c, k;
    logic [RW-1:0]      r;
    logic [CW-1:0]      cnt;
    logic [PW-1:0]      ph;
    logic               f_bit;

    dst40_f u_f (
        .c (c[DST40_W-2:0]),
        .k (k),
        .f (f_bit)
    );

    assign out_chal = c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = (NSTEP == 0) ? S_ROUND : S_FFWD;
            end
            S_FFWD: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) state_n = S_ROUND;
            end
            S_ROUND: begin
                busy = 1'b1;
                if (r == '0) state_n = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath: load job, fast-forward key to its last schedule step, then unwind rounds.
    // ph tracks r % KEY_PERIOD so the key steps back right after the first round of each period.
    always_ff @(posedge clk) begin
        if (rst) begin
            c   <= '0;
            k   <= '0;
            r   <= '0;
            cnt <= '0;
            ph  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        c   <= in_state;
                        k   <= in_key;
                        cnt <= '0;
                        r   <= R_LAST;
                        ph  <= PH_START;
                    end
                end
                S_FFWD: begin
                    k   <= key_fwd(k);
                    cnt <= cnt + 1'b1;
                end
                S_ROUND: begin
                    c <= chal_bwd(c, f_bit);
                    if (ph == '0) begin
                        ph <= PH_RELOAD;
                        if (r != '0) k <= key_bwd(k);
                    end else begin
                        ph <= ph - 1'b1;
                    end
                    if (r != '0) r <= r - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
